// File: rtl/fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_pkg                                                            |
// | Shared types and constants for the instruction fetch unit.           |
// | Optional build macro used by the fetch unit: FETCH_HALT_EN.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fetch_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_QDEPTH = 2;

   // Top nibble of an instruction word that stops fetch when halt is built in
   localparam logic [3:0] HALT_OPCODE = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_HOLD  = 3'd2,
      S_DRAIN = 3'd3,
      S_HALT  = 3'd4
   } fetch_state_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_queue                                                          |
// | Small synchronous FIFO holding {addr, data} fetch entries.           |
// | Flush has priority over push and pop. Head entry is combinational.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_queue #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;
   logic               w_do_push;
   logic               w_do_pop;

   assign o_full    = (r_count == c_depth);
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   // A push into a full queue is accepted only when the head leaves in the same cycle
   assign w_do_push = i_push && (!o_full || i_pop);
   assign w_do_pop  = i_pop && !o_empty;

   // Storage array; contents are only meaningful where the count says so
   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy tracking, flush empties the queue outright
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_cnt_w'(1);
            2'b01:   r_count <= r_count - c_cnt_w'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch                                                    |
// | Program counter, single-outstanding req/ack memory fetch, small      |
// | fetch queue and one-per-cycle issue to the decoder with branch       |
// | redirect and decoder stall.                                          |
// | Optional macro FETCH_HALT_EN: HALT_OPCODE words stop fetch and issue |
// | until the next branch.                                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int QDEPTH = DEF_QDEPTH
) (
   input  logic              clock,
   input  logic              reset,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              branch_valid,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              stall,
   output logic [DATA_W-1:0] instruct,
   output logic              enable,
   output logic [ADDR_W-1:0] pc_out
);

   localparam int c_entry_w = ADDR_W + DATA_W;
   localparam int c_cnt_w   = $clog2(QDEPTH) + 1;
   localparam logic [c_cnt_w-1:0] c_last_free = c_cnt_w'(QDEPTH - 1);

   fetch_state_t         r_state;
   fetch_state_t         w_state_nxt;
   logic [ADDR_W-1:0]    r_fetch_pc;
   logic [ADDR_W-1:0]    w_fetch_pc_nxt;
   logic [ADDR_W-1:0]    r_target;
   logic [ADDR_W-1:0]    w_target_nxt;
`ifdef FETCH_HALT_EN
   logic                 r_halt_pend;
   logic                 w_halt_pend_nxt;
`endif

   logic [c_entry_w-1:0] w_head;
   logic [ADDR_W-1:0]    w_head_addr;
   logic [DATA_W-1:0]    w_head_data;
   logic                 w_full;
   logic                 w_empty;
   logic [c_cnt_w-1:0]   w_count;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_flush;
   logic                 w_halt_pop;
   logic                 w_outstanding;

   assign w_head_addr   = w_head[c_entry_w-1 -: ADDR_W];
   assign w_head_data   = w_head[DATA_W-1:0];
   // Branch beats both stall and issue
   assign w_pop         = !w_empty && !stall && !branch_valid;
   assign w_outstanding = mem_req && !mem_ack;
`ifdef FETCH_HALT_EN
   assign w_halt_pop    = w_pop && (w_head_data[DATA_W-1 -: 4] == HALT_OPCODE);
`else
   assign w_halt_pop    = 1'b0;
`endif
   // Words returned during a redirect or a halt are dropped, never queued
   assign w_push  = (r_state == S_FETCH) && mem_req && mem_ack && !branch_valid && !w_halt_pop;
   assign w_flush = branch_valid || w_halt_pop;

   fetch_queue #(
      .WIDTH (c_entry_w),
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk     (clock),
      .rst     (reset),
      .i_push  (w_push),
      .i_data  ({r_fetch_pc, mem_rdata}),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // State, program counter and pending redirect target
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_fetch_pc  <= '0;
         r_target    <= '0;
`ifdef FETCH_HALT_EN
         r_halt_pend <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_fetch_pc  <= w_fetch_pc_nxt;
         r_target    <= w_target_nxt;
`ifdef FETCH_HALT_EN
         r_halt_pend <= w_halt_pend_nxt;
`endif
      end
   end

   // Next-state logic; fetch_pc keeps the old address while draining so mem_addr stays stable
   always_comb begin
      w_state_nxt     = r_state;
      w_fetch_pc_nxt  = r_fetch_pc;
      w_target_nxt    = r_target;
`ifdef FETCH_HALT_EN
      w_halt_pend_nxt = r_halt_pend;
`endif
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (branch_valid) begin
               if (w_outstanding) begin
                  w_state_nxt  = S_DRAIN;
                  w_target_nxt = branch_target;
               end else begin
                  w_fetch_pc_nxt = branch_target;
               end
            end
`ifdef FETCH_HALT_EN
            else if (w_halt_pop) begin
               if (w_outstanding) begin
                  w_state_nxt     = S_DRAIN;
                  w_halt_pend_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_HALT;
               end
            end
`endif
            else if (mem_req && mem_ack) begin
               w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(1);
               if ((w_count == c_last_free) && !w_pop) begin
                  w_state_nxt = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (branch_valid) begin
               w_fetch_pc_nxt = branch_target;
               w_state_nxt    = S_FETCH;
            end
`ifdef FETCH_HALT_EN
            else if (w_halt_pop) begin
               w_state_nxt = S_HALT;
            end
`endif
            else if (w_pop) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (branch_valid) begin
               w_target_nxt    = branch_target;
`ifdef FETCH_HALT_EN
               w_halt_pend_nxt = 1'b0;
`endif
            end
            if (mem_ack) begin
               w_fetch_pc_nxt = branch_valid ? branch_target : r_target;
               w_state_nxt    = S_FETCH;
`ifdef FETCH_HALT_EN
               w_halt_pend_nxt = 1'b0;
               if (r_halt_pend && !branch_valid) begin
                  w_state_nxt    = S_HALT;
                  w_fetch_pc_nxt = r_fetch_pc;
               end
`endif
            end
         end
`ifdef FETCH_HALT_EN
         S_HALT: begin
            if (branch_valid) begin
               w_fetch_pc_nxt = branch_target;
               w_state_nxt    = S_FETCH;
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Memory request outputs; a request is never raised while the queue is full
   always_comb begin
      mem_addr = r_fetch_pc;
      case (r_state)
         S_FETCH: mem_req = !w_full;
         S_DRAIN: mem_req = 1'b1;
         default: mem_req = 1'b0;
      endcase
   end

   // Registered issue stage: the popped entry appears one cycle later with enable
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         instruct <= '0;
         pc_out   <= '0;
         enable   <= 1'b0;
      end else begin
         enable <= w_pop;
         if (w_pop) begin
            instruct <= w_head_data;
            pc_out   <= w_head_addr;
         end
      end
   end

endmodule : instruction_fetch
`default_nettype wire
